// File: rtl/vga_fix.sv
// Static Pong frame on 640x480@60 VGA from a 100 MHz clock: sync generator plus pixel painter.
// Optional ROUND_BALL_EN masks the 8x8 ball with a round bitmap.
module vga_fix #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_DISPLAY + H_FRONT + H_RETRACE + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_DISPLAY + V_FRONT + V_RETRACE + V_BACK - 1);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY - 1);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY - 1);

    localparam logic [9:0] WALL_X_L = 10'd32;
    localparam logic [9:0] WALL_X_R = 10'd35;
    localparam logic [9:0] PAD_X_L  = 10'd600;
    localparam logic [9:0] PAD_X_R  = 10'd603;
    localparam logic [9:0] PAD_Y_T  = 10'd204;
    localparam logic [9:0] PAD_Y_B  = 10'd275;
    localparam logic [9:0] BALL_X_L = 10'd580;
    localparam logic [9:0] BALL_X_R = 10'd587;
    localparam logic [9:0] BALL_Y_T = 10'd238;
    localparam logic [9:0] BALL_Y_B = 10'd245;

    logic [1:0] div_q, div_d;
    logic [9:0] h_count_q, h_count_d;
    logic [9:0] v_count_q, v_count_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       pixel_tick;
    logic       h_end, v_end;

    always_comb begin
        div_d      = div_q + 2'd1;
        pixel_tick = (div_q == DIV_LAST);
        h_end      = (h_count_q == H_LAST);
        v_end      = (v_count_q == V_LAST);
        h_count_d  = h_count_q;
        v_count_d  = v_count_q;
        if (pixel_tick) begin
            if (h_end) begin
                h_count_d = '0;
                v_count_d = v_end ? '0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
        end
        // Decode the next count so the registered sync lines up with it.
        hsync_d = !((h_count_d >= HS_START) && (h_count_d <= HS_END));
        vsync_d = !((v_count_d >= VS_START) && (v_count_d <= VS_END));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q     <= '0;
            h_count_q <= '0;
            v_count_q <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;

    logic video_on;
    logic wall_on, paddle_on, ball_box, ball_on;

    assign video_on = (h_count_q <= H_VIS) && (v_count_q <= V_VIS);

    assign wall_on = (h_count_q >= WALL_X_L) && (h_count_q <= WALL_X_R)
                  && (v_count_q <= V_VIS);

    assign paddle_on = (h_count_q >= PAD_X_L) && (h_count_q <= PAD_X_R)
                    && (v_count_q >= PAD_Y_T) && (v_count_q <= PAD_Y_B);

    assign ball_box = (h_count_q >= BALL_X_L) && (h_count_q <= BALL_X_R)
                   && (v_count_q >= BALL_Y_T) && (v_count_q <= BALL_Y_B);

`ifdef ROUND_BALL_EN
    logic [2:0] ball_row, ball_col;
    logic [7:0] rom_bits;

    assign ball_row = 3'(v_count_q - BALL_Y_T);
    assign ball_col = 3'(h_count_q - BALL_X_L);

    always_comb begin
        rom_bits = 8'hFF;
        unique case (ball_row)
            3'd0, 3'd7: rom_bits = 8'h3C;
            3'd1, 3'd6: rom_bits = 8'h7E;
            default:    rom_bits = 8'hFF;
        endcase
    end

    // Column 0 is the leftmost pixel, stored in the MSB.
    assign ball_on = ball_box && rom_bits[3'd7 - ball_col];
`else
    assign ball_on = ball_box;
`endif

    always_comb begin
        r = 4'h0;
        g = 4'h0;
        b = 4'h0;
        if (reset && video_on) begin
            if (wall_on) begin
                r = 4'hF;
            end else if (paddle_on) begin
                g = 4'hF;
            end else if (ball_on) begin
                b = 4'hF;
            end
        end
    end

endmodule

// File: tb/tb_vga_fix.sv
// Directed bench for vga_fix: a cycle model feeds a scoreboard queue
// that is popped and compared against the DUT on each falling edge.
module tb_vga_fix;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync, vsync;
    logic [3:0] r, g, b;

    vga_fix dut (
        .clk   (clk),
        .reset (reset),
        .hsync (hsync),
        .vsync (vsync),
        .r     (r),
        .g     (g),
        .b     (b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mdiv = 0;
    int mx = 0;
    int my = 0;
    int ticks = 0;
    bit saw_hwrap = 0;
    bit saw_vwrap = 0;
    logic [13:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h (x=%0d y=%0d)",
                   tag, obs, exp, mx, my);
        end
    endtask

    function automatic logic exp_hs(input int x);
        return !(x >= 656 && x <= 751);
    endfunction

    function automatic logic exp_vs(input int y);
        return !(y >= 490 && y <= 491);
    endfunction

    function automatic logic [11:0] exp_rgb(input int x, input int y);
        logic [7:0] rb;
        if (!(x < 640 && y < 480)) return 12'h000;
        if (x >= 32 && x <= 35) return 12'hF00;
        if (x >= 600 && x <= 603 && y >= 204 && y <= 275) return 12'h0F0;
        if (x >= 580 && x <= 587 && y >= 238 && y <= 245) begin
`ifdef ROUND_BALL_EN
            case (y - 238)
                0, 7:    rb = 8'h3C;
                1, 6:    rb = 8'h7E;
                default: rb = 8'hFF;
            endcase
            return rb[7 - (x - 580)] ? 12'h00F : 12'h000;
`else
            rb = 8'hFF;
            return rb[0] ? 12'h00F : 12'h000;
`endif
        end
        return 12'h000;
    endfunction

    task automatic step();
        logic [13:0] e;
        int px;
        int py;
        @(posedge clk);
        px = mx;
        py = my;
        if (mdiv == 3) begin
            if (mx == 799) begin
                mx = 0;
                if (my == 524) my = 0;
                else my++;
            end else begin
                mx++;
            end
        end
        mdiv = (mdiv + 1) % 4;
        if (px == 799 && mx == 0) saw_hwrap = 1;
        if (py == 524 && my == 0) saw_vwrap = 1;
        sb.push_back({exp_hs(mx), exp_vs(my), exp_rgb(mx, my)});
        @(negedge clk);
        e = sb.pop_front();
        chk("tick", 32'(dut.pixel_tick), 32'(mdiv == 3));
        if (dut.pixel_tick) ticks++;
        chk("h_count", 32'(dut.h_count_q), 32'(mx));
        chk("v_count", 32'(dut.v_count_q), 32'(my));
        chk("hsync", 32'(hsync), 32'(e[13]));
        chk("vsync", 32'(vsync), 32'(e[12]));
        chk("rgb", {20'h0, r, g, b}, {20'h0, e[11:0]});
        if (mx == 33 && my == 100) chk("pt_wall", {20'h0, r, g, b}, 32'hF00);
        if (mx == 601 && my == 240) chk("pt_paddle", {20'h0, r, g, b}, 32'h0F0);
        if (mx == 583 && my == 241) chk("pt_ball", {20'h0, r, g, b}, 32'h00F);
        if (mx == 300 && my == 300) chk("pt_bg", {20'h0, r, g, b}, 32'h000);
        if (mx == 599 && my == 240) chk("pt_not_green", 32'(g == 4'hF), 32'h0);
        if (mx == 583 && my == 238) chk("pt_ball_top", {20'h0, r, g, b}, 32'h00F);
`ifdef ROUND_BALL_EN
        if (mx == 580 && my == 238) chk("pt_corner", {20'h0, r, g, b}, 32'h000);
`else
        if (mx == 580 && my == 238) chk("pt_corner", {20'h0, r, g, b}, 32'h00F);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Jump the raster to (x, y) so distant lines are reached quickly.
    task automatic jump(input int x, input int y);
        force dut.h_count_q = 10'(x);
        force dut.v_count_q = 10'(y);
        #1;
        release dut.h_count_q;
        release dut.v_count_q;
        mx = x;
        my = y;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hsync", 32'(hsync), 32'h0);
            chk("rst_vsync", 32'(vsync), 32'h0);
            chk("rst_rgb", {20'h0, r, g, b}, 32'h0);
        end
        reset = 1'b1;
        mdiv = 0;
        mx = 0;
        my = 0;
        chk("rel_h", 32'(dut.h_count_q), 32'h0);
        chk("rel_v", 32'(dut.v_count_q), 32'h0);

        ticks = 0;
        run(400);
        chk("tick_count", 32'(ticks), 32'd100);
        chk("h_after_400", 32'(dut.h_count_q), 32'd100);

        run(3200);
        chk("h_wrapped", 32'(saw_hwrap), 32'h1);

        jump(790, 477);
        run(4 * 800 * 4);

        jump(795, 524);
        run(40);
        chk("v_wrapped", 32'(saw_vwrap), 32'h1);

        jump(30, 100);
        run(48);
        jump(595, 240);
        run(48);
        jump(578, 241);
        run(48);
        jump(578, 238);
        run(48);
        jump(298, 300);
        run(48);
        jump(30, 479);
        run(48);
        jump(30, 480);
        run(48);
        jump(635, 204);
        run(4 * 170);

        jump(31, 100);
        run(12);
        reset = 1'b0;
        #1;
        chk("rst_gate_rgb", {20'h0, r, g, b}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_h_zero", 32'(dut.h_count_q), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_fix.md
Name: vga_fix

Overview:
- Top-level static Pong display for a 640x480 at 60 Hz VGA monitor, driven from a 100 MHz system clock.
- Contains two parts:
  - a VGA sync generator: pixel-tick divider, horizontal/vertical counters, sync pulses, video-on decode.
  - a pixel generator: draws a fixed wall, paddle and ball in solid colours.
- Drives the board's 12-bit VGA connector directly.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_RETRACE, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_RETRACE, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIX_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)

Ports:
- clk  input  1  100 MHz system clock; all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- hsync  output  1  horizontal sync, active-low pulse
- vsync  output  1  vertical sync, active-low pulse
- r  output  4  red intensity
- g  output  4  green intensity
- b  output  4  blue intensity

Behaviour:
- Reset:
  - While reset=0 at a clock edge, the divider counter, h_count and v_count all go to 0.
  - hsync and vsync registers are cleared to 0.
  - r/g/b are forced to 0 while reset is asserted.
- Pixel tick:
  - 2-bit divider counts 0..3 every clock, wrapping 3->0.
  - pixel_tick is high only in the cycle where the divider equals 3, i.e. one clock in four.
  - pixel_tick is never high for any other divider value.
- Horizontal counter (h_count, 10 bits):
  - Increments on pixel_tick.
  - h_end = (h_count == 799).
  - On h_end with pixel_tick, h_count wraps to 0; it never reaches 800.
- Vertical counter (v_count, 10 bits):
  - Increments when pixel_tick and h_end are both high.
  - v_end = (v_count == 524).
  - Wraps to 0 on v_end; it never reaches 525.
- Sync outputs:
  - hsync is registered from next-count decode and stays aligned with h_count.
  - hsync = 0 for h_count 656..751, otherwise 1.
  - vsync = 0 for v_count 490..491, otherwise 1.
- Video-on decode:
  - h_video_on = (h_count <= 639).
  - v_video_on = (v_count <= 479).
  - video_on = h_video_on & v_video_on.
  - Whenever video_on is 1, hsync and vsync are both 1.
- Object decode from the current counters (bounds inclusive):
  - wall_on: x 32..35, y 0..479.
  - paddle_on: x 600..603, y 204..275.
  - ball_on: x 580..587, y 238..245.
- Colour:
  - rgb is combinational from the registered counters, with zero added latency; the colour matches the current (x, y) in the same cycle.
  - Priority: wall, then paddle, then ball, then background.
  - wall = F/0/0, paddle = 0/F/0, ball = 0/0/F, background = 0/0/0.
  - When video_on = 0 or reset is asserted, r = g = b = 0.
- Frame timing: one frame = 800 x 525 pixel ticks = 1,680,000 clocks.

Optional Feature:
- Macro: ROUND_BALL_EN.
- When defined:
  - ball_on additionally requires a set bit in an 8x8 ROM.
  - ROM rows, MSB = leftmost: 3C, 7E, FF, FF, FF, FF, 7E, 3C.
  - Row index = y - 238, column index = x - 580.
- When undefined: the ball is the full 8x8 square.

Test Plan:
- Reset: hold reset=0 for 2 clocks, then release -> during reset hsync=0, vsync=0, r=g=b=0; h_count=0 and v_count=0 on release.
- Pixel tick: run 400 clocks after reset -> pixel_tick high exactly when the divider equals 3, 100 times; h_count advances 0->100.
- Line timing: run one line -> h_count goes 799->0; hsync=0 exactly for x 656..751; h_video_on=0 for x >= 640.
- Frame timing: run one frame -> v_count goes 524->0; vsync=0 only for y 490..491; rgb=0 for all y >= 480 and all x >= 640.
- Objects, sampled at each pixel_tick:
  - (33,100) -> F/0/0
  - (601,240) -> 0/F/0
  - (583,241) -> 0/0/F
  - (300,300) -> 0/0/0
  - (599,240) -> not green
- ROUND_BALL_EN defined: (580,238) -> 0/0/0 and (583,238) -> 0/0/F; undefined: (580,238) -> 0/0/F.
